// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one cache port between instruction fetch (port 0)
// and data access (port 1), with a response watchdog and saturating hit/miss counters.
module cache_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7,
  parameter int unsigned SW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          c_req,
  output logic          c_wr,
  output logic [31:0]   c_addr,
  output logic [31:0]   c_data,
  input  logic          c_response,
  input  logic [31:0]   c_out,
  input  logic          c_miss,
  output logic [SW-1:0] hit_cnt,
  output logic [SW-1:0] miss_cnt
);

  localparam logic [SW-1:0] CNT_MAX = {SW{1'b1}};
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] wcnt, wcnt_nxt;
  logic          grant, grant_nxt;
  logic          last_grant, last_grant_nxt;
  logic          pick;
  logic          ack0_nxt, ack1_nxt, err_nxt, c_req_nxt, c_wr_nxt;
  logic [31:0]   rdata_nxt, c_addr_nxt, c_data_nxt;
  logic [SW-1:0] hit_cnt_nxt, miss_cnt_nxt;

  // State and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      c_req      <= 1'b0;
      c_wr       <= 1'b0;
      c_addr     <= '0;
      c_data     <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      err        <= err_nxt;
      rdata      <= rdata_nxt;
      c_req      <= c_req_nxt;
      c_wr       <= c_wr_nxt;
      c_addr     <= c_addr_nxt;
      c_data     <= c_data_nxt;
      hit_cnt    <= hit_cnt_nxt;
      miss_cnt   <= miss_cnt_nxt;
    end
  end

  // Next-state and next-output logic; ack and c_req are single-cycle pulses
  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    pick           = 1'b0;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    err_nxt        = err;
    rdata_nxt      = rdata;
    c_req_nxt      = 1'b0;
    c_wr_nxt       = c_wr;
    c_addr_nxt     = c_addr;
    c_data_nxt     = c_data;
    hit_cnt_nxt    = hit_cnt;
    miss_cnt_nxt   = miss_cnt;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the port that did not win last time
          pick           = (req0 && req1) ? ~last_grant : req1;
          grant_nxt      = pick;
          last_grant_nxt = pick;
          c_wr_nxt       = pick ? wr1    : wr0;
          c_addr_nxt     = pick ? addr1  : addr0;
          c_data_nxt     = pick ? wdata1 : wdata0;
          c_req_nxt      = 1'b1;
          state_nxt      = ISSUE;
        end
      end

      ISSUE: begin
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end

      WAIT: begin
        // The first WAIT cycle may still see the previous transaction's response
        if (wcnt != '0 && c_response) begin
          err_nxt   = 1'b0;
          rdata_nxt = c_wr ? 32'd0 : c_out;
          if (!c_wr) begin
            if (c_miss) begin
              if (miss_cnt != CNT_MAX) miss_cnt_nxt = miss_cnt + SW'(1);
            end else begin
              if (hit_cnt != CNT_MAX) hit_cnt_nxt = hit_cnt + SW'(1);
            end
          end
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          state_nxt = RESP;
        end else if (wcnt == WAIT_MAX) begin
          err_nxt   = 1'b1;
          rdata_nxt = 32'd0;
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          state_nxt = RESP;
        end else begin
          wcnt_nxt = wcnt + TW'(1);
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
